dot_product_chunk_accumulator: RTL and testbench
================================================

# dot_product_chunk_accumulator

Downstream consumer of the 8-lane tree-add dot-product units. It accepts a programmed number of 19-bit partial dot products, one per `in_valid`/`in_ready` handshake, and sums them into a wide accumulator. This produces the dot product of vectors longer than 8 elements. The final sum is presented on a `res_valid`/`res_ready` output handshake and held until it is consumed.

## Interface
- `IN_W`, default 19: width of each incoming partial dot product.
- `ACC_W`, default 32: accumulator and result width; must satisfy ACC_W ≥ IN_W.
- `LEN_W`, default 8: width of the chunk-count field.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a new accumulation; sampled only in IDLE.
- `num_chunks`  in  LEN_W  number of partials to sum; sampled with `start`.
- `in_valid`  in  1  partial product present on `dot_product`.
- `dot_product`  in  IN_W  unsigned partial dot product.
- `in_ready`  out  1  high only in ACCUM.
- `result`  out  ACC_W  accumulated sum; stable while `res_valid` is high.
- `res_valid`  out  1  result available; high only in DONE.
- `res_ready`  in  1  consumer accepts the result.
- `busy`  out  1  high when the state is not IDLE.
- `chunk_count`  out  LEN_W  partials accepted so far in the current job.
- `overflow`  out  1  sticky per job; an add exceeded 2^ACC_W−1.

## Operation
- States are IDLE, ACCUM and DONE.
- IDLE:
  - `start`=1 latches `num_chunks` into `len_q`, clears the accumulator, `chunk_count` and `overflow`.
  - Next state is ACCUM when `num_chunks`≠0.
  - Next state is DONE with `result`=0 when `num_chunks`=0.
- ACCUM:
  - `in_ready`=1.
  - Each cycle with `in_valid`&`in_ready`: acc ← acc + zero-extended `dot_product`, and `chunk_count` increments.
  - When the accepted partial is number `len_q` (`chunk_count`==`len_q`−1 at the edge), next state is DONE.
  - `in_valid`=0 cycles stall without limit; the state is held.
- DONE:
  - `res_valid`=1, `result`=acc.
  - `res_valid`&`res_ready` at an edge moves to IDLE.
  - `res_valid` does not drop until that edge.
- `start` is ignored outside IDLE, and so are changes to `num_chunks`.
- `in_valid` outside ACCUM is ignored; no data is consumed because `in_ready`=0.
- Arithmetic:
  - Unsigned.
  - The adder is ACC_W+1 bits wide.
  - Carry-out sets `overflow` (sticky until the next accepted `start`).
- Reset mid-operation: everything returns to reset values immediately, and the job is lost.

## Timing
- Reset values:
  - state=IDLE.
  - `in_ready`=0, `res_valid`=0, `busy`=0, `overflow`=0.
  - `result`=0, `chunk_count`=0.
- `start` accepted at edge t: `in_ready`=1 from t+1.
- A handshake at edge t updates acc and `chunk_count`, visible after t.
- Last partial accepted at edge t: `res_valid`=1 and `result` valid from t+1.
  - This is one cycle of latency after the final handshake.
- The minimum job of N chunks with no stalls is start edge + N accept edges + 1 result-consume edge.
- `in_ready` and `res_valid` are decoded purely from registered state; there is no combinational path from any input.
- After the result is consumed at edge t, the state is IDLE at t+1, and `start` is accepted at edge t+1 at the earliest.
  - There is always one IDLE cycle between jobs.
- `start` asserted in the same cycle as the consuming `res_ready` is ignored.

## Configuration
- `DOTACC_SATURATE_EN` defined:
  - On carry-out the accumulator clamps to 2^ACC_W−1.
  - It remains clamped for the rest of the job.
  - `overflow` is set.
- `DOTACC_SATURATE_EN` undefined:
  - The accumulator wraps modulo 2^ACC_W.
  - `overflow` is still set on carry-out.
  - All other behaviour is identical.

## Test plan
- Basic sum:
  - Stimulus: reset, then `start` with `num_chunks`=3, then partials 100, 2000, 524287 with no stalls.
  - Required response: `result`=526387 one cycle after the third handshake, `overflow`=0, `chunk_count`=3.
- Stalls:
  - Stimulus: `num_chunks`=2, with `in_valid` low for 5 cycles between partials 7 and 9.
  - Required response: `result`=16, and `res_valid` stays low until the cycle after the second handshake.
- Zero length and backpressure:
  - Stimulus: `num_chunks`=0, with `res_ready` held low for 4 cycles.
  - Required response: `res_valid`=1 and `result`=0 from the cycle after `start`, held for all 4 cycles; IDLE one cycle after `res_ready`.
- Ignored inputs:
  - Stimulus: `start` and `num_chunks`=9 pulsed during ACCUM of a 2-chunk job; `in_valid`=1 driven in IDLE and DONE.
  - Required response: the job completes after 2 partials, and no extra data is consumed (`in_ready`=0).
- Overflow, with ACC_W=20 and `num_chunks`=3 of 524287:
  - With `DOTACC_SATURATE_EN`: `result`=1048575 and `overflow`=1.
  - Without it: `result`=524285 and `overflow`=1.
- Reset mid-operation:
  - Stimulus: `rst_n` low after 1 of 4 partials.
  - Required response: all outputs at reset values within the same cycle; a new 1-chunk job of 5 then returns 5.

Source files
------------

// File: rtl/dot_product_chunk_accumulator.sv
// Sums a programmed number of unsigned partial dot products into a wide accumulator.
// Define DOTACC_SATURATE_EN to clamp on carry-out instead of wrapping.
module dot_product_chunk_accumulator #(
    parameter int IN_W  = 19,
    parameter int ACC_W = 32,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] num_chunks,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  dot_product,
    output logic             in_ready,
    output logic [ACC_W-1:0] result,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             busy,
    output logic [LEN_W-1:0] chunk_count,
    output logic             overflow
);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t           state;
    logic [LEN_W-1:0] len_q;
    logic [ACC_W-1:0] acc;
    logic [ACC_W:0]   sum;

    // The top bit of sum is the carry-out that flags overflow.
    function automatic logic [ACC_W-1:0] acc_limit(input logic [ACC_W:0] s);
`ifdef DOTACC_SATURATE_EN
        return s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
`else
        return s[ACC_W-1:0];
`endif
    endfunction

    assign sum       = {1'b0, acc} + {{(ACC_W + 1 - IN_W){1'b0}}, dot_product};
    assign in_ready  = (state == ACCUM);
    assign res_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign result    = acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            len_q       <= '0;
            acc         <= '0;
            chunk_count <= '0;
            overflow    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        len_q       <= num_chunks;
                        acc         <= '0;
                        chunk_count <= '0;
                        overflow    <= 1'b0;
                        state       <= (num_chunks == '0) ? DONE : ACCUM;
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        acc         <= acc_limit(sum);
                        chunk_count <= chunk_count + LEN_W'(1);
                        if (sum[ACC_W])
                            overflow <= 1'b1;
                        if (chunk_count == len_q - LEN_W'(1))
                            state <= DONE;
                    end
                end
                DONE: begin
                    if (res_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dot_product_chunk_accumulator.sv
// Randomized and directed bench for dot_product_chunk_accumulator with a running-total model.
module tb_dot_product_chunk_accumulator;

    localparam int IN_W  = 19;
    localparam int ACC_W = 20;
    localparam int LEN_W = 8;
    localparam longint MAXV = (64'd1 << ACC_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [LEN_W-1:0] num_chunks = '0;
    logic             in_valid = 1'b0;
    logic [IN_W-1:0]  dot_product = '0;
    logic             in_ready;
    logic [ACC_W-1:0] result;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic             busy;
    logic [LEN_W-1:0] chunk_count;
    logic             overflow;

    int checks = 0;
    int errors = 0;

    logic [IN_W-1:0] data_q  [0:15];
    int              stall_q [0:15];

    dot_product_chunk_accumulator #(.IN_W(IN_W), .ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_chunks(num_chunks),
        .in_valid(in_valid), .dot_product(dot_product), .in_ready(in_ready),
        .result(result), .res_valid(res_valid), .res_ready(res_ready),
        .busy(busy), .chunk_count(chunk_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_busy"},  64'(busy), 64'd0);
        check({tag, "_rdy"},   64'(in_ready), 64'd0);
        check({tag, "_rv"},    64'(res_valid), 64'd0);
        check({tag, "_ovf"},   64'(overflow), 64'd0);
        check({tag, "_res"},   64'(result), 64'd0);
        check({tag, "_cnt"},   64'(chunk_count), 64'd0);
    endtask

    // One complete job: n partials from data_q with stall_q idle cycles before each,
    // then the result held under backpressure for hold cycles before being consumed.
    task automatic run_job(input string tag, input int n, input int hold, input bit noise);
        longint exp_acc = 0;
        bit     exp_ovf = 1'b0;
        for (int i = 0; i < n; i++) begin
            longint s = exp_acc + longint'(data_q[i]);
            if (s > MAXV) begin
                exp_ovf = 1'b1;
`ifdef DOTACC_SATURATE_EN
                s = MAXV;
`else
                s = s % (MAXV + 1);
`endif
            end
            exp_acc = s;
        end

        start = 1'b1;
        num_chunks = LEN_W'(n);
        step();
        start = 1'b0;
        num_chunks = 8'd9;
        check({tag, "_busy"}, 64'(busy), 64'd1);

        for (int i = 0; i < n; i++) begin
            for (int s = 0; s < stall_q[i]; s++) begin
                in_valid = 1'b0;
                start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                check({tag, "_stall_rdy"}, 64'(in_ready), 64'd1);
                check({tag, "_stall_rv"}, 64'(res_valid), 64'd0);
                step();
            end
            start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            in_valid = 1'b1;
            dot_product = data_q[i];
            check({tag, "_rdy"}, 64'(in_ready), 64'd1);
            check({tag, "_rv_early"}, 64'(res_valid), 64'd0);
            step();
            in_valid = 1'b0;
            start = 1'b0;
            check({tag, "_cnt"}, 64'(chunk_count), 64'(i + 1));
        end

        check({tag, "_rv"}, 64'(res_valid), 64'd1);
        check({tag, "_done_rdy"}, 64'(in_ready), 64'd0);
        check({tag, "_res"}, 64'(result), 64'(exp_acc));
        check({tag, "_ovf"}, 64'(overflow), 64'(exp_ovf));
        check({tag, "_cnt_done"}, 64'(chunk_count), 64'(n));

        for (int h = 0; h < hold; h++) begin
            res_ready = 1'b0;
            in_valid = 1'b1;
            dot_product = IN_W'($urandom);
            start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            step();
            check({tag, "_hold_rv"}, 64'(res_valid), 64'd1);
            check({tag, "_hold_res"}, 64'(result), 64'(exp_acc));
            check({tag, "_hold_cnt"}, 64'(chunk_count), 64'(n));
        end

        // start coinciding with the consuming edge must be ignored
        res_ready = 1'b1;
        start = 1'b1;
        in_valid = 1'b0;
        step();
        res_ready = 1'b0;
        start = 1'b0;
        check({tag, "_idle_busy"}, 64'(busy), 64'd0);
        check({tag, "_idle_rv"}, 64'(res_valid), 64'd0);

        in_valid = 1'b1;
        check({tag, "_idle_rdy"}, 64'(in_ready), 64'd0);
        step();
        in_valid = 1'b0;
        check({tag, "_idle_cnt"}, 64'(chunk_count), 64'(n));
        check({tag, "_idle_busy2"}, 64'(busy), 64'd0);
    endtask

    task automatic clear_stalls();
        for (int i = 0; i < 16; i++) stall_q[i] = 0;
    endtask

    initial begin
        #12;
        check_reset_values("reset");
        rst_n = 1'b1;
        step();

        clear_stalls();
        data_q[0] = 19'd100; data_q[1] = 19'd2000; data_q[2] = 19'd524287;
        run_job("basic", 3, 0, 1'b0);

        clear_stalls();
        data_q[0] = 19'd7; data_q[1] = 19'd9; stall_q[1] = 5;
        run_job("stall", 2, 0, 1'b0);

        clear_stalls();
        run_job("zero", 0, 4, 1'b0);

        clear_stalls();
        data_q[0] = 19'd11; data_q[1] = 19'd22; stall_q[1] = 2;
        run_job("ignore", 2, 2, 1'b1);

        clear_stalls();
        for (int i = 0; i < 3; i++) data_q[i] = 19'd524287;
        run_job("ovf", 3, 1, 1'b0);

        // reset in the middle of a 4-chunk job
        clear_stalls();
        start = 1'b1;
        num_chunks = 8'd4;
        step();
        start = 1'b0;
        in_valid = 1'b1;
        dot_product = 19'd1234;
        step();
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_values("midrst");
        #3;
        rst_n = 1'b1;
        step();
        data_q[0] = 19'd5;
        run_job("after_rst", 1, 0, 1'b0);

        for (int j = 0; j < 25; j++) begin
            int n = $urandom_range(1, 10);
            for (int i = 0; i < n; i++) begin
                data_q[i] = ($urandom_range(0, 3) == 0) ? 19'd524287 : IN_W'($urandom);
                stall_q[i] = $urandom_range(0, 2);
            end
            run_job("rand", n, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
